// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter sharing one code-converter datapath among NREQ requesters.
// Outputs are decoded from registers only; a job occupies START, WAIT (bounded by TIMEOUT) and RESP.
module code_conv_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [2*NREQ-1:0]  req_sel,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               conv_start,
  output logic [DW-1:0]      conv_data,
  output logic [1:0]         conv_sel,
  input  logic               conv_done,
  input  logic [DW-1:0]      conv_result,
  output logic               busy
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   op_q;
  logic [1:0]      sel_q;
  logic [DW-1:0]   res_q;
  logic            err_q;
  logic [NREQ-1:0] owner_oh;

  // First requester at or above rr_ptr, wrapping past NREQ-1 back to 0.
  always_comb begin
    logic         found;
    logic [IW1-1:0] idx;
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + IW1'(i);
      if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      timer  <= '0;
      op_q   <= '0;
      sel_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= pick;
            op_q  <= req_data[int'(pick)*DW +: DW];
            sel_q <= req_sel[int'(pick)*2 +: 2];
            state <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TW'(1);
          // A done arriving on the last allowed cycle still counts as success.
          if (conv_done) begin
            res_q <= conv_result;
            err_q <= 1'b0;
            state <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_q <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner_oh   = NREQ'(1) << owner;
  assign busy       = (state != IDLE);
  assign gnt        = busy ? owner_oh : '0;
  assign conv_start = (state == START);
  assign rsp_valid  = (state == RESP) ? owner_oh : '0;
  assign conv_data  = op_q;
  assign conv_sel   = sel_q;
  assign rsp_data   = res_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Table-driven bench for code_conv_arbiter with a response scoreboard queue.
module tb_code_conv_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [2*NREQ-1:0]  req_sel;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               conv_start;
  logic [DW-1:0]      conv_data;
  logic [1:0]         conv_sel;
  logic               conv_done;
  logic [DW-1:0]      conv_result;
  logic               busy;

  code_conv_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_sel(req_sel),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .conv_start(conv_start), .conv_data(conv_data), .conv_sel(conv_sel),
    .conv_done(conv_done), .conv_result(conv_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // dly: WAIT cycle (1..TIMEOUT) on whose closing edge conv_done is sampled; 0 = never.
  typedef struct {
    logic [NREQ-1:0] req;
    logic [DW-1:0]   data;
    logic [1:0]      sel;
    int              owner;
    int              dly;
    logic [DW-1:0]   res;
    bit              drop;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [DW-1:0]   dat;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.dat));
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic do_job(input vec_t v);
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   exp_dat;
    logic [1:0]      exp_sel;
    exp_t            e;
    bit              found;
    int              lat;
    oh      = NREQ'(1) << v.owner;
    exp_dat = v.data + DW'(v.owner);
    exp_sel = v.sel ^ 2'(v.owner);
    req     = v.req;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = v.data + DW'(i);
      req_sel[i*2 +: 2]    = v.sel ^ 2'(i);
    end
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (conv_start) begin
        found = 1'b1;
        break;
      end
    end
    chk("start_seen", 32'(found), 32'd1);
    if (!found) begin
      req = '0;
      return;
    end
    chk("gnt_start", 32'(gnt), 32'(oh));
    chk("conv_data", 32'(conv_data), 32'(exp_dat));
    chk("conv_sel", 32'(conv_sel), 32'(exp_sel));
    chk("busy_start", 32'(busy), 32'd1);
    e.vld = oh;
    e.dat = (v.dly > 0) ? v.res : '0;
    e.err = (v.dly == 0);
    exp_q.push_back(e);
    // Operand changes after latching must not reach the converter.
    req_data = ~req_data;
    req_sel  = ~req_sel;
    if (v.drop) req = '0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        lat = c;
        break;
      end
      conv_done   = (c == v.dly);
      conv_result = v.res;
    end
    conv_done = 1'b0;
    chk("latency", 32'(lat), (v.dly > 0) ? 32'(v.dly + 1) : 32'(TIMEOUT + 1));
    chk("gnt_resp", 32'(gnt), 32'(oh));
    chk("conv_data_hold", 32'(conv_data), 32'(exp_dat));
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    req = '0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; req = '0; req_data = '0; req_sel = '0;
    conv_done = 1'b0; conv_result = '0;

    vt[0] = '{4'b1111, 8'h10, 2'b01, 0, 3,  8'hA1, 1'b0};
    vt[1] = '{4'b1111, 8'h10, 2'b01, 1, 1,  8'hA2, 1'b0};
    vt[2] = '{4'b1111, 8'h10, 2'b01, 2, 2,  8'hA3, 1'b0};
    vt[3] = '{4'b1111, 8'h10, 2'b01, 3, 4,  8'hA4, 1'b0};
    vt[4] = '{4'b1111, 8'h10, 2'b01, 0, 1,  8'hA5, 1'b0};
    vt[5] = '{4'b0100, 8'h40, 2'b10, 2, 2,  8'hB2, 1'b0};
    vt[6] = '{4'b0101, 8'h50, 2'b11, 0, 3,  8'hC0, 1'b0};
    vt[7] = '{4'b0001, 8'h2D, 2'b01, 0, 5,  8'h3B, 1'b1};
    vt[8] = '{4'b1000, 8'h77, 2'b10, 3, TIMEOUT, 8'h5C, 1'b0};
    vt[9] = '{4'b0010, 8'h99, 2'b11, 1, 0,  8'hEE, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_start", 32'(conv_start), 32'd0);
    chk("rst_conv_data", 32'(conv_data), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_job(vt[i]);

    // Late/stray conv_done while idle must be ignored.
    @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("stray_busy_later", 32'(busy), 32'd0);
    chk("stray_err_hold", 32'(rsp_err), 32'd1);

    // Reset in the middle of WAIT.
    req = 4'b0100;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (conv_start) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_start_seen", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(conv_start), 32'd0);
    chk("mid_rst_err", 32'(rsp_err), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    do_job('{4'b0010, 8'h61, 2'b10, 1, 2, 8'h42, 1'b0});

    repeat (3) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_conv_arbiter.md
Name: code_conv_arbiter

Overview:
- Shares one code-converter datapath and its sequencing controller among NREQ requesters.
- The converter handles pass-through, Gray, BCD and Excess-3 conversions.
- Selects a requester by round-robin and latches its operand and conversion select.
- Pulses the converter start, waits for the converter's execution-over flag (with a timeout), then returns the result to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, operand/result width in bits.
- TIMEOUT, 64, max WAIT cycles before a job is aborted with error (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until that requester's rsp_valid.
- req_data  in  NREQ*DW  operands; requester i occupies bits [i*DW +: DW].
- req_sel  in  2*NREQ  conversion selects; requester i occupies bits [i*2 +: 2]. 00 = none, 01 = Gray, 10 = BCD, 11 = Excess-3.
- gnt  out  NREQ  one-hot grant; held for the whole job.
- rsp_valid  out  NREQ  one-cycle response strobe to the granted requester.
- rsp_data  out  DW  shared result bus; valid when any rsp_valid bit is 1.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort.
- conv_start  out  1  one-cycle start pulse to the converter controller.
- conv_data  out  DW  latched operand to the converter.
- conv_sel  out  2  latched select to the converter.
- conv_done  in  1  converter execution-over flag (single-cycle pulse).
- conv_result  in  DW  converter result; valid while conv_done=1.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- States: IDLE, START, WAIT, RESP.
- All outputs are decoded from registered state and registers only; there is no combinational input-to-output path.
- Reset (async, any state including mid-job):
  - state = IDLE, rr pointer = 0, timer = 0.
  - Latched owner, operand and select registers = 0.
  - gnt = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, conv_start = 0, conv_data = 0, conv_sel = 0, busy = 0.
- IDLE:
  - If req != 0, pick the first set bit searching upward from the rr pointer, wrapping at NREQ-1 -> 0.
  - Latch the winner index, req_data slice and req_sel slice; go to START.
  - If req == 0, stay in IDLE.
- START:
  - gnt[owner] = 1, conv_start = 1 for exactly this cycle.
  - conv_data/conv_sel = latched values; they stay stable through START, WAIT and RESP.
  - Clear timer; go to WAIT.
- WAIT:
  - gnt held; timer increments each cycle.
  - conv_done = 1: capture conv_result into rsp_data, rsp_err = 0, go to RESP.
  - Otherwise, if timer == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - If conv_done and the timeout coincide, conv_done wins (no error).
- RESP:
  - rsp_valid[owner] = 1 for one cycle; gnt[owner] still 1.
  - rr pointer <= (owner+1) mod NREQ; go to IDLE.
  - gnt falls on the next cycle.
- Latency:
  - req sampled at edge N -> START during cycle N+1.
  - With conv_done seen during cycle N+1+k, rsp_valid is 1 during cycle N+2+k.
- Minimum spacing between consecutive grants: RESP -> IDLE -> START, i.e. 3 cycles start-to-start plus the converter time.
- conv_done in IDLE, START or RESP is ignored; it creates no response and changes no state.
- Requester dropping req after grant: the job still completes and the response is still issued.
- req data/sel changes after latching have no effect on the current job.
- rsp_data and rsp_err hold their last value in IDLE until the next job's capture.
- Timeout does not reset the converter; the system must tolerate a late conv_done (ignored per the rule above).

Test Plan:
- Single job:
  - req=0001, req_data[0]=8'h2D, sel=01.
  - Converter returns 8'h3B after 5 cycles -> gnt=0001, conv_start for 1 cycle, conv_data=8'h2D, conv_sel=01.
  - Then rsp_valid=0001 with rsp_data=8'h3B, rsp_err=0.
- Simultaneous contention:
  - req=1111 held, pointer starts at 0.
  - Grants are issued in order 0,1,2,3,0; each rsp_valid goes only to the granted bit.
- Round-robin fairness:
  - After requester 2 is served, req=0101 -> requester 0 granted next (wrap), not 2.
- Timeout:
  - conv_done never asserted, TIMEOUT=64 -> rsp_valid after 64 WAIT cycles with rsp_err=1, rsp_data=0.
  - A late conv_done afterwards is ignored.
- Reset mid-WAIT:
  - Assert rst during WAIT -> gnt, busy and conv_start go to 0 immediately; no rsp_valid.
  - The next req=0010 is granted from IDLE.
- Done/timeout collision and stray done:
  - conv_done on cycle TIMEOUT-1 of WAIT -> rsp_err=0 with the captured result.
  - conv_done pulsed in IDLE -> no rsp_valid, busy stays 0.
